// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: entry layout and 2-bit direction counter.
// The counter field exists only when BP_BIMODAL_EN is defined.
package bp_pkg;

  // Widest tag needed: the smallest table (4 entries) leaves 28 bits above the index.
  localparam int BP_TAG_W = 28;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_ctr_t;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [31:0]         target;
    logic                uncond;
`ifdef BP_BIMODAL_EN
    bp_ctr_t             ctr;
`endif
  } bp_entry_t;

  localparam bp_ctr_t BP_CTR_RESET = WEAK_NT;

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next-state function of a 2-bit saturating direction counter.
// Holds its value when inc and dec are both set or both clear.
module bp_sat_counter
  import bp_pkg::*;
(
  input  bp_ctr_t ctr,
  input  logic    inc,
  input  logic    dec,
  output bp_ctr_t ctr_next
);

  // NOTE: default assignment first so no path through the block leaves ctr_next unassigned (no latch).
  always_comb begin
    ctr_next = ctr;
    if (inc && !dec) begin
      if (ctr != STRONG_T) ctr_next = bp_ctr_t'(ctr + 2'd1);
    end else if (dec && !inc) begin
      if (ctr != STRONG_NT) ctr_next = bp_ctr_t'(ctr - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with optional bimodal direction counters (macro BP_BIMODAL_EN).
// Zero-latency lookup, one-cycle update with no bypass, plus branch/mispredict counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] lookup_pc,
  output logic [31:0] pred_next_pc,
  output logic        pred_taken,
  output logic        pred_hit,
  input  logic        update_valid,
  input  logic        update_taken,
  input  logic        update_mispredicted,
  input  logic        update_unconditional,
  input  logic [31:0] update_addr,
  input  logic [31:0] update_target,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int TAG_W = 30 - IDX_W;

  function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  function automatic logic [BP_TAG_W-1:0] tag_of(input logic [31:0] pc);
    return BP_TAG_W'(pc[31:IDX_W+2]);
  endfunction

  logic [ENTRIES-1:0]  valid_q;
  logic [ENTRIES-1:0]  uncond_q;
  logic [BP_TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
`ifdef BP_BIMODAL_EN
  bp_ctr_t             ctr_q    [ENTRIES];
  bp_ctr_t             ctr_next;
`endif

  logic [31:0] branch_cnt_q;
  logic [31:0] mispredict_cnt_q;

  logic [IDX_W-1:0]    lk_idx, upd_idx;
  logic [BP_TAG_W-1:0] lk_tag, upd_tag;
  logic                upd_hit;
  bp_entry_t           lk_entry;

  assign lk_idx  = idx_of(lookup_pc);
  assign lk_tag  = tag_of(lookup_pc);
  assign upd_idx = idx_of(update_addr);
  assign upd_tag = tag_of(update_addr);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    lk_entry.valid  = valid_q[lk_idx];
    lk_entry.tag    = tag_q[lk_idx];
    lk_entry.target = target_q[lk_idx];
    lk_entry.uncond = uncond_q[lk_idx];
`ifdef BP_BIMODAL_EN
    lk_entry.ctr    = ctr_q[lk_idx];
`endif
  end

  assign pred_hit = lk_entry.valid && (lk_entry.tag == lk_tag);
`ifdef BP_BIMODAL_EN
  assign pred_taken = pred_hit && (lk_entry.uncond || lk_entry.ctr[1]);
`else
  assign pred_taken = pred_hit;
  logic unused_uncond;
  assign unused_uncond = lk_entry.uncond;
`endif
  assign pred_next_pc = pred_taken ? lk_entry.target : lookup_pc + 32'd4;

  // Word-aligned PCs: the byte-offset bits carry no information.
  logic unused_offset;
  assign unused_offset = ^{lookup_pc[1:0], update_addr[1:0]};

`ifdef BP_BIMODAL_EN
  bp_sat_counter u_sat_counter (
    .ctr      (ctr_q[upd_idx]),
    .inc      (update_taken),
    .dec      (!update_taken),
    .ctr_next (ctr_next)
  );
`endif

  // Valid bits (and counters) are the only per-entry state that needs a known reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
`ifdef BP_BIMODAL_EN
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= BP_CTR_RESET;
`endif
    end else if (update_valid) begin
      if (update_taken) begin
        valid_q[upd_idx] <= 1'b1;
`ifdef BP_BIMODAL_EN
        ctr_q[upd_idx] <= upd_hit ? ctr_next
                                  : (update_unconditional ? STRONG_T : WEAK_T);
`endif
      end else if (upd_hit) begin
`ifdef BP_BIMODAL_EN
        ctr_q[upd_idx] <= ctr_next;
`else
        valid_q[upd_idx] <= 1'b0;
`endif
      end
    end
  end

  // NOTE: payload arrays are deliberately left without reset; an invalid entry never exposes them.
  always_ff @(posedge clk) begin
    if (update_valid && update_taken) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= update_target;
      uncond_q[upd_idx] <= update_unconditional;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (update_valid) begin
      branch_cnt_q <= branch_cnt_q + 32'd1;
      if (update_mispredicted) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispredict_cnt_q;

  // Keeps TAG_W meaningful for readers: the stored tag is zero-extended to BP_TAG_W.
  if (TAG_W > BP_TAG_W) begin : g_bad_entries
    $error("ENTRIES must be at least 4");
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: table of update+lookup vectors checked via a
// scoreboard queue, then hand sequences for same-cycle update, counter wrap and async reset.
module tb_branch_predictor;

  localparam bit BIM =
`ifdef BP_BIMODAL_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] lookup_pc;
  logic [31:0] pred_next_pc;
  logic        pred_taken;
  logic        pred_hit;
  logic        update_valid;
  logic        update_taken;
  logic        update_mispredicted;
  logic        update_unconditional;
  logic [31:0] update_addr;
  logic [31:0] update_target;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .lookup_pc            (lookup_pc),
    .pred_next_pc         (pred_next_pc),
    .pred_taken           (pred_taken),
    .pred_hit             (pred_hit),
    .update_valid         (update_valid),
    .update_taken         (update_taken),
    .update_mispredicted  (update_mispredicted),
    .update_unconditional (update_unconditional),
    .update_addr          (update_addr),
    .update_target        (update_target),
    .branch_count         (branch_count),
    .mispredict_count     (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        uv, ut, um, uu;
    logic [31:0] ua, utgt, lk;
    logic        e_hit, e_taken;
    logic [31:0] e_next;
  } vec_t;

  typedef struct {
    logic        hit, taken;
    logic [31:0] next;
  } exp_t;

  vec_t vecs [12];
  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic uv, ut, um, uu, input logic [31:0] ua, utgt, lk,
                              input logic e_hit, e_taken, input logic [31:0] e_next);
    vec_t v;
    v.uv = uv; v.ut = ut; v.um = um; v.uu = uu;
    v.ua = ua; v.utgt = utgt; v.lk = lk;
    v.e_hit = e_hit; v.e_taken = e_taken; v.e_next = e_next;
    return v;
  endfunction

  task automatic drive_update(input logic uv, ut, um, uu, input logic [31:0] ua, utgt);
    update_valid         = uv;
    update_taken         = ut;
    update_mispredicted  = um;
    update_unconditional = uu;
    update_addr          = ua;
    update_target        = utgt;
  endtask

  task automatic clear_update();
    drive_update(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst_n     = 1'b1;
    lookup_pc = 32'h100;
    clear_update();
    #1 rst_n = 1'b0;
    #20 rst_n = 1'b1;

    // uv  ut  um  uu  addr          target        lookup        hit   taken  next
    vecs[0]  = mk(0, 0, 0, 0, 32'h100, 32'h0,    32'h100,      0,    0,     32'h104);
    vecs[1]  = mk(1, 1, 0, 0, 32'h100, 32'h200,  32'h100,      1,    1,     32'h200);
    vecs[2]  = mk(1, 0, 1, 0, 32'h100, 32'h0,    32'h100,      BIM,  0,     32'h104);
    vecs[3]  = mk(1, 0, 0, 0, 32'h100, 32'h0,    32'h100,      BIM,  0,     32'h104);
    vecs[4]  = mk(1, 1, 1, 1, 32'h140, 32'h400,  32'h100,      0,    0,     32'h104);
    vecs[5]  = mk(0, 0, 0, 0, 32'h140, 32'h0,    32'h140,      1,    1,     32'h400);
    vecs[6]  = mk(1, 0, 1, 0, 32'h140, 32'h0,    32'h140,      BIM,  BIM,   BIM ? 32'h400 : 32'h144);
    vecs[7]  = mk(1, 0, 0, 0, 32'h140, 32'h0,    32'h140,      BIM,  BIM,   BIM ? 32'h400 : 32'h144);
    vecs[8]  = mk(1, 0, 0, 0, 32'h140, 32'h0,    32'h140,      BIM,  BIM,   BIM ? 32'h400 : 32'h144);
    vecs[9]  = mk(0, 1, 1, 0, 32'h300, 32'h900,  32'h300,      0,    0,     32'h304);
    vecs[10] = mk(1, 1, 0, 0, 32'h204, 32'h1000, 32'h204,      1,    1,     32'h1000);
    vecs[11] = mk(0, 0, 0, 0, 32'h0,   32'h0,    32'hFFFF_FFFC, 0,   0,     32'h0);

    @(negedge clk);
    check("reset branch_count", branch_count, 32'd0);
    check("reset mispredict_count", mispredict_count, 32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive_update(vecs[i].uv, vecs[i].ut, vecs[i].um, vecs[i].uu, vecs[i].ua, vecs[i].utgt);
      @(posedge clk);
      #1;
      clear_update();
      lookup_pc = vecs[i].lk;
      e.hit = vecs[i].e_hit; e.taken = vecs[i].e_taken; e.next = vecs[i].e_next;
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL scoreboard empty at vector %0d", i);
      end else begin
        e = sb.pop_front();
        check($sformatf("vec%0d pred_hit", i), {31'd0, pred_hit}, {31'd0, e.hit});
        check($sformatf("vec%0d pred_taken", i), {31'd0, pred_taken}, {31'd0, e.taken});
        check($sformatf("vec%0d pred_next_pc", i), pred_next_pc, e.next);
      end
    end
    check("table branch_count", branch_count, 32'd8);
    check("table mispredict_count", mispredict_count, 32'd3);

    // Same-cycle update and lookup of one index: old contents now, new ones next cycle.
    @(negedge clk);
    drive_update(1'b1, 1'b1, 1'b0, 1'b0, 32'h008, 32'h800);
    lookup_pc = 32'h008;
    #1;
    check("same-cycle pred_hit", {31'd0, pred_hit}, 32'd0);
    check("same-cycle pred_next_pc", pred_next_pc, 32'h00C);
    @(posedge clk);
    #1;
    clear_update();
    @(negedge clk);
    check("next-cycle pred_hit", {31'd0, pred_hit}, 32'd1);
    check("next-cycle pred_next_pc", pred_next_pc, 32'h800);
    check("same-cycle branch_count", branch_count, 32'd9);

    // Mispredict counter wrap.
    force dut.mispredict_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.mispredict_cnt_q;
    check("preload mispredict_count", mispredict_count, 32'hFFFF_FFFF);
    drive_update(1'b1, 1'b0, 1'b1, 1'b0, 32'h3F0, 32'h0);
    @(posedge clk);
    #1;
    clear_update();
    check("wrap mispredict_count", mispredict_count, 32'd0);
    check("wrap branch_count", branch_count, 32'd10);

    // Asynchronous reset in the middle of an update.
    @(negedge clk);
    lookup_pc = 32'h204;
    #1;
    check("pre-reset pred_next_pc", pred_next_pc, 32'h1000);
    drive_update(1'b1, 1'b1, 1'b1, 1'b0, 32'h00C, 32'h050);
    #1 rst_n = 1'b0;
    #1;
    check("async reset pred_hit", {31'd0, pred_hit}, 32'd0);
    check("async reset pred_taken", {31'd0, pred_taken}, 32'd0);
    check("async reset pred_next_pc", pred_next_pc, 32'h208);
    check("async reset branch_count", branch_count, 32'd0);
    check("async reset mispredict_count", mispredict_count, 32'd0);
    @(posedge clk);
    #1;
    check("in-reset branch_count", branch_count, 32'd0);
    @(negedge clk);
    lookup_pc = 32'h00C;
    #1;
    check("in-reset update ignored", {31'd0, pred_hit}, 32'd0);
    drive_update(1'b1, 1'b1, 1'b0, 1'b0, 32'h00C, 32'h050);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_update();
    check("first update pred_hit", {31'd0, pred_hit}, 32'd1);
    check("first update pred_next_pc", pred_next_pc, 32'h050);
    check("first update branch_count", branch_count, 32'd1);
    check("first update mispredict_count", mispredict_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Branch target buffer with bimodal direction prediction for the Fetch stage. Each cycle it turns the fetch PC into a predicted next PC. It trains on the branch-update bundle that WriteBack produces for every resolved branch. Fetch passes the predicted next PC down the pipe, and WriteBack compares it against the resolved target to detect mispredictions.

## Interface
Parameters:
- `ENTRIES`, 16: BTB entries; power of two, 4..256.
- `IDX_W`, `$clog2(ENTRIES)`: index width; derived, not overridden.

Ports:
- `clk`  input  1: clock, rising edge.
- `rst_n`  input  1: reset, asynchronous, active-low.
- `lookup_pc`  input  32: current fetch PC, word aligned.
- `pred_next_pc`  output  32: predicted next PC.
- `pred_taken`  output  1: prediction is a taken branch.
- `pred_hit`  output  1: `lookup_pc` hit a valid BTB entry.
- `update_valid`  input  1: resolved-branch bundle is valid this cycle.
- `update_taken`  input  1: branch was taken.
- `update_mispredicted`  input  1: WriteBack detected a wrong prediction.
- `update_unconditional`  input  1: JAL/JALR.
- `update_addr`  input  32: PC of the branch.
- `update_target`  input  32: resolved next PC.
- `branch_count`  output  32: number of accepted updates.
- `mispredict_count`  output  32: number of accepted updates that were mispredicted.

## Operation
- Index: `pc[IDX_W+1:2]`. Tag: `pc[31:IDX_W+2]`.
- Entry fields: `valid`, `tag`, `target`, `uncond`, `ctr[1:0]`.
- Lookup is purely combinational:
  - hit = `valid` && tag match.
  - `pred_taken` = hit && (`uncond` || `ctr[1]`).
  - `pred_next_pc` = `target` when `pred_taken`, else `lookup_pc + 4` (modulo 2^32).
- Update, applied only when `update_valid`:
  - Taken, hit: write `target` and `uncond`; `ctr` increments, saturating at 11.
  - Taken, miss: allocate by overwriting the entry at that index (direct-mapped). Set `valid`=1 and write `tag`/`target`/`uncond`. Initial `ctr` is 11 if unconditional, else 10.
  - Not taken, hit: `ctr` decrements, saturating at 00. The entry stays valid.
  - Not taken, miss: no change.
- Counters:
  - `branch_count` increments on every `update_valid`.
  - `mispredict_count` increments when `update_valid && update_mispredicted`.
  - Both wrap from 0xFFFF_FFFF to 0.
- `update_mispredicted` is never asserted without `update_valid`. If it is, it is ignored.

## Timing
- Lookup latency: 0 cycles. Outputs follow `lookup_pc` within the same cycle.
- Update latency: 1 cycle. The write occurs at the rising edge where `update_valid`=1. A lookup of the same index first sees the new entry in the following cycle.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update contents. There is no bypass.
- Reset (asserted, any time, including mid-update):
  - All `valid` cleared, `ctr` set to 01, both counters set to 0.
  - `tag`, `target` and `uncond` arrays are not reset.
  - With all entries invalid, `pred_hit`=0, `pred_taken`=0 and `pred_next_pc`=`lookup_pc+4`.
- Release of `rst_n` is synchronized externally. The first update is accepted at the first rising edge after deassertion.

## Configuration
- `BP_BIMODAL_EN` defined: per-entry 2-bit counters, behaving as described above.
- `BP_BIMODAL_EN` undefined:
  - No `ctr` storage.
  - `pred_taken` = hit.
  - Taken update: allocates or refreshes the entry.
  - Not-taken update on a hit: clears `valid`.
  - All other behaviour, including the performance counters, is unchanged.

## Structure
- Package `bp_pkg` contains:
  - typedef `bp_ctr_t`, an enum: `STRONG_NT`=00, `WEAK_NT`=01, `WEAK_T`=10, `STRONG_T`=11.
  - typedef `bp_entry_t`, a packed struct of the entry fields, with `ctr` present only under `BP_BIMODAL_EN`.
  - constant `BP_CTR_RESET` = `WEAK_NT`.
- One sub-module, `bp_sat_counter`: a combinational 2-bit saturating next-state function. It takes the current counter, `inc` and `dec`, and returns the next counter. It is instantiated once, on the update path.

## Test plan
- Reset, then lookup 0x100: `pred_hit`=0, `pred_taken`=0, `pred_next_pc`=0x104, both counters 0.
- Taken conditional update with addr 0x100, target 0x200, then lookup 0x100: hit, `pred_taken`=1, `pred_next_pc`=0x200, `branch_count`=1.
- Two not-taken updates to 0x100 (`ctr` 10→01→00), then lookup: hit, `pred_taken`=0, `pred_next_pc`=0x104. Without `BP_BIMODAL_EN`, the first not-taken update makes `pred_hit`=0.
- Alias with ENTRIES=16:
  - JAL at 0x140 (same index as 0x100, different tag), target 0x400.
  - Lookup 0x100: miss.
  - Lookup 0x140: `pred_next_pc`=0x400.
  - Three not-taken updates to 0x140: it still predicts taken, because `uncond`=1.
- Update and lookup of the same index in the same cycle: the old prediction is returned. The new prediction appears in the next cycle.
- Preload `mispredict_count` to 0xFFFF_FFFF by forcing, then apply one mispredicted update: it wraps to 0. Assert `rst_n` low mid-stream: all outputs return to their reset values asynchronously.
